// File: rtl/motor_uart_pkg.sv
// Shared constants and types for the motor-control UART link.
// Used by the command receiver and the telemetry transmitter.
package motor_uart_pkg;

    localparam logic [7:0] HDR_RPM   = 8'h92;
    localparam logic [7:0] TERM_BYTE = 8'hFF;

    localparam int CHN_WIDTH = 3;
    localparam int VAL_WIDTH = 13;
    localparam int MAX_CHN   = 4;

    localparam int A_CHN_LSB = 5;
    localparam int A_VAL_MSB = 4;
    localparam int BYTE_BITS = 8;

    localparam int SAT_MAX = 4095;
    localparam int SAT_MIN = -4096;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_CHN_HI,
        TX_CHN_LO,
        TX_TERM
    } tx_state_e;

    function automatic logic [7:0] chn_hi_byte(
        input logic [1:0]           chn,
        input logic [VAL_WIDTH-1:0] val
    );
        return {1'b0, chn, val[VAL_WIDTH-1:BYTE_BITS]};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit.
// done pulses in the last cycle of the stop bit so a new byte can follow with no gap.
module uart_tx_byte #(
    parameter int BAUD_CLK = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int CW = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shr_q, shr_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          bit_end;

    assign bit_end = busy_q && (cnt_q == CW'(BAUD_CLK - 1));
    assign done    = bit_end && (bit_q == 4'd9);
    assign tx      = tx_q;
    assign busy    = busy_q;

    // Next-state: load on start, otherwise step baud counter and bit index.
    always_comb begin
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        shr_d  = shr_q;
        tx_d   = tx_q;
        busy_d = busy_q;
        if (start && (!busy_q || done)) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bit_d  = 4'd0;
            shr_d  = data;
            tx_d   = 1'b0;
        end else if (busy_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d  = shr_q[0];
                        shr_d = {1'b0, shr_q[7:1]};
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; line idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bit_q  <= 4'd0;
            shr_q  <= 8'h00;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            shr_q  <= shr_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/uart_telemetry_tx.sv
// Telemetry transmitter: holds saturated per-channel samples and, on request,
// sends header, two bytes per channel and a terminator over the UART line.
module uart_telemetry_tx
    import motor_uart_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         NUM_CHN    = 4,
    parameter int         CLK_FREQ   = 27_000_000,
    parameter int         BAUD_RATE  = 115200,
    parameter logic [7:0] HDR_BYTE   = HDR_RPM,
    parameter logic [7:0] TRM_BYTE   = TERM_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tr_valid_i,
    input  logic [CHN_WIDTH-1:0]  tr_chn_i,
    input  logic [DATA_WIDTH-1:0] tr_data_i,
    input  logic                  send_i,
    output logic                  busy_o,
    output logic                  uart_tx
);

    localparam int BAUD_CLK = CLK_FREQ / BAUD_RATE;

    localparam logic signed [DATA_WIDTH-1:0] LIM_HI = DATA_WIDTH'(SAT_MAX);
    localparam logic signed [DATA_WIDTH-1:0] LIM_LO = DATA_WIDTH'(SAT_MIN);

    logic [VAL_WIDTH-1:0] ch_q [MAX_CHN];
    logic [VAL_WIDTH-1:0] ch_d [MAX_CHN];
    logic [VAL_WIDTH-1:0] snap_q [MAX_CHN];
    logic [VAL_WIDTH-1:0] snap_d [MAX_CHN];

    tx_state_e            state_q, state_d;
    logic [CHN_WIDTH-1:0] chn_q, chn_d;
    logic [CHN_WIDTH-1:0] chn_nxt;
    logic [VAL_WIDTH-1:0] sat_val;
    logic signed [DATA_WIDTH-1:0] sample;

    logic       byte_start;
    logic [7:0] byte_data;
    logic       byte_done;
    logic       byte_busy;

    assign chn_nxt = chn_q + CHN_WIDTH'(1);

    // Clamp the incoming sample to the 13-bit signed wire range.
    always_comb begin
        sample = tr_data_i;
        if (sample > LIM_HI) begin
            sat_val = VAL_WIDTH'(SAT_MAX);
        end else if (sample < LIM_LO) begin
            sat_val = VAL_WIDTH'(SAT_MIN);
        end else begin
            sat_val = sample[VAL_WIDTH-1:0];
        end
    end

    // Channel bank write and snapshot with write-through of a coincident write.
    always_comb begin
        ch_d   = ch_q;
        snap_d = snap_q;
        if (tr_valid_i && (tr_chn_i < CHN_WIDTH'(NUM_CHN))) begin
            ch_d[tr_chn_i[1:0]] = sat_val;
        end
        if ((state_q == TX_IDLE) && send_i) begin
            snap_d = ch_d;
        end
    end

    // Frame sequencer: each state hands the next byte to the engine on done.
    always_comb begin
        state_d    = state_q;
        chn_d      = chn_q;
        byte_start = 1'b0;
        byte_data  = HDR_BYTE;
        unique case (state_q)
            TX_IDLE: begin
                if (send_i) begin
                    byte_start = 1'b1;
                    byte_data  = HDR_BYTE;
                    state_d    = TX_HDR;
                end
            end
            TX_HDR: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    byte_data  = chn_hi_byte(2'd0, snap_q[0]);
                    chn_d      = '0;
                    state_d    = TX_CHN_HI;
                end
            end
            TX_CHN_HI: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    byte_data  = snap_q[chn_q[1:0]][7:0];
                    state_d    = TX_CHN_LO;
                end
            end
            TX_CHN_LO: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (chn_q == CHN_WIDTH'(NUM_CHN - 1)) begin
                        byte_data = TRM_BYTE;
                        state_d   = TX_TERM;
                    end else begin
                        byte_data = chn_hi_byte(chn_nxt[1:0],
                                                snap_q[chn_nxt[1:0]]);
                        chn_d     = chn_nxt;
                        state_d   = TX_CHN_HI;
                    end
                end
            end
            TX_TERM: begin
                if (byte_done) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Registers for bank, snapshot, sequencer state and channel counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_CHN; i++) begin
                ch_q[i]   <= '0;
                snap_q[i] <= '0;
            end
            state_q <= TX_IDLE;
            chn_q   <= '0;
        end else begin
            ch_q    <= ch_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            chn_q   <= chn_d;
        end
    end

    assign busy_o = (state_q != TX_IDLE) || byte_busy;

    uart_tx_byte #(
        .BAUD_CLK (BAUD_CLK)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (uart_tx),
        .done  (byte_done),
        .busy  (byte_busy)
    );

endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Bench for uart_telemetry_tx: decodes the serial line mid-bit and
// compares frames against a value-level model of the channel registers.
module tb_uart_telemetry_tx;

    localparam int CLK_FREQ  = 27_000_000;
    localparam int BAUD_RATE = 1_000_000;
    localparam int BAUD      = CLK_FREQ / BAUD_RATE;
    localparam int NCH       = 4;
    localparam int FLEN      = 2 + 2 * NCH;
    localparam int FRAME_CYC = FLEN * 10 * BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tr_valid_i = 1'b0;
    logic [2:0]  tr_chn_i = 3'd0;
    logic [15:0] tr_data_i = 16'h0000;
    logic        send_i = 1'b0;
    logic        busy_o;
    logic        uart_tx;

    int errors = 0;
    int checks = 0;

    int mdl [NCH];
    int snap_m [NCH];
    int rx [FLEN];
    int rx_bad;

    uart_telemetry_tx #(
        .DATA_WIDTH (16),
        .NUM_CHN    (NCH),
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tr_valid_i (tr_valid_i),
        .tr_chn_i   (tr_chn_i),
        .tr_data_i  (tr_data_i),
        .send_i     (send_i),
        .busy_o     (busy_o),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    function automatic int sat13(input int v);
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    function automatic int exp_byte(input int idx);
        int c;
        int v;
        if (idx == 0) return 'h92;
        if (idx == FLEN - 1) return 'hFF;
        c = (idx - 1) / 2;
        v = snap_m[c] & 'h1FFF;
        if (((idx - 1) % 2) == 0) return (c << 5) | (v >> 8);
        return v & 'hFF;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) mdl[i] = 0;
    endtask

    task automatic wr(input int c, input logic [15:0] d);
        tr_valid_i = 1'b1;
        tr_chn_i   = 3'(c);
        tr_data_i  = d;
        @(negedge clk);
        tr_valid_i = 1'b0;
        if (c < NCH) mdl[c] = sat13(int'($signed(d)));
    endtask

    task automatic send();
        send_i = 1'b1;
        snap_m = mdl;
        @(negedge clk);
        send_i = 1'b0;
    endtask

    function automatic logic [15:0] rnd_sample();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'(4095 + $urandom_range(0, 3));
            3: return 16'(-4097 + $urandom_range(0, 3));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic recv_frame();
        int lim;
        int v;
        bit lost;
        rx_bad = 0;
        lost = 0;
        for (int k = 0; k < FLEN; k++) begin
            rx[k] = -1;
            if (!lost) begin
                lim = (k == 0) ? 4 * BAUD : 2 * BAUD;
                while (uart_tx !== 1'b0 && lim > 0) begin
                    @(negedge clk);
                    lim--;
                end
                if (uart_tx !== 1'b0) begin
                    lost = 1;
                    rx_bad++;
                end else begin
                    repeat (BAUD / 2) @(negedge clk);
                    if (uart_tx !== 1'b0) rx_bad++;
                    v = 0;
                    for (int i = 0; i < 8; i++) begin
                        repeat (BAUD) @(negedge clk);
                        if (uart_tx === 1'b1) v |= (1 << i);
                    end
                    repeat (BAUD) @(negedge clk);
                    if (uart_tx !== 1'b1) rx_bad++;
                    rx[k] = v;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(5);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got %b want 1", uart_tx);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy_o);
        end
        rst = 1'b0;
        clear_model();
        cyc(2);
        send();
        recv_frame();
        checks++;
        if (rx_bad !== 0) begin
            errors++;
            $display("FAIL reset_framing got %0d want 0", rx_bad);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL reset_byte%0d got %0h want %0h",
                         k, rx[k], exp_byte(k));
            end
        end
    endtask

    task automatic test_pattern();
        int lit [FLEN];
        lit = '{'h92, 'h11, 'hA8, 'h29, 'hA9, 'h55, 'h0A, 'h75, 'hFF, 'hFF};
        cyc(3 * BAUD);
        wr(0, 16'(-3672));
        wr(1, 16'(2473));
        wr(2, 16'(-2806));
        wr(3, 16'(-2561));
        send();
        recv_frame();
        checks++;
        if (rx_bad !== 0) begin
            errors++;
            $display("FAIL pattern_framing got %0d want 0", rx_bad);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== lit[k] || rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL pattern_byte%0d got %0h want %0h",
                         k, rx[k], lit[k]);
            end
        end
    endtask

    task automatic test_saturation();
        cyc(3 * BAUD);
        wr(0, 16'h7FFF);
        wr(1, 16'h8000);
        wr(2, 16'd424);
        wr(3, rnd_sample());
        send();
        recv_frame();
        checks++;
        if (rx_bad !== 0) begin
            errors++;
            $display("FAIL sat_framing got %0d want 0", rx_bad);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL sat_byte%0d got %0h want %0h",
                         k, rx[k], exp_byte(k));
            end
        end
        checks++;
        if (rx[1] !== 'h0F || rx[2] !== 'hFF || rx[3] !== 'h30 ||
            rx[4] !== 'h00 || rx[5] !== 'h41 || rx[6] !== 'hA8) begin
            errors++;
            $display("FAIL sat_literal got %0h %0h %0h %0h %0h %0h want 0f ff 30 00 41 a8",
                     rx[1], rx[2], rx[3], rx[4], rx[5], rx[6]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            cyc($urandom_range(1, 3 * BAUD));
            for (int w = 0; w < 8; w++) wr($urandom_range(0, 7), rnd_sample());
            send();
            recv_frame();
            checks++;
            if (rx_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_framing got %0d want 0", it, rx_bad);
            end
            for (int k = 0; k < FLEN; k++) begin
                checks++;
                if (rx[k] !== exp_byte(k)) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d got %0h want %0h",
                             it, k, rx[k], exp_byte(k));
                end
            end
        end
    endtask

    task automatic test_busy();
        int lows;
        cyc(3 * BAUD);
        for (int c = 0; c < NCH; c++) wr(c, rnd_sample());
        send();
        fork
            recv_frame();
            begin
                cyc(FRAME_CYC / 2);
                send_i     = 1'b1;
                tr_valid_i = 1'b1;
                tr_chn_i   = 3'd0;
                tr_data_i  = 16'd100;
                @(negedge clk);
                send_i     = 1'b0;
                tr_valid_i = 1'b0;
                mdl[0]     = 100;
            end
        join
        checks++;
        if (rx_bad !== 0) begin
            errors++;
            $display("FAIL busy_framing got %0d want 0", rx_bad);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL busy_byte%0d got %0h want %0h",
                         k, rx[k], exp_byte(k));
            end
        end
        cyc(BAUD);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_after got %b want 0", busy_o);
        end
        lows = 0;
        for (int i = 0; i < 3 * BAUD; i++) begin
            if (uart_tx !== 1'b1 || busy_o !== 1'b0) lows++;
            @(negedge clk);
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL busy_no_queue got %0d active cycles want 0", lows);
        end
        send();
        recv_frame();
        checks++;
        if (rx[1] !== 'h00 || rx[2] !== 'h64) begin
            errors++;
            $display("FAIL busy_next_ch0 got %0h %0h want 00 64", rx[1], rx[2]);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL busy_next_byte%0d got %0h want %0h",
                         k, rx[k], exp_byte(k));
            end
        end
    endtask

    task automatic test_timing();
        int busy_n;
        int low1;
        int high1;
        int phase;
        int lim;
        cyc(3 * BAUD);
        send();
        busy_n = 0;
        low1 = 0;
        high1 = 0;
        phase = 0;
        lim = FRAME_CYC + 100;
        while (busy_o === 1'b1 && lim > 0) begin
            busy_n++;
            if (phase == 0 && uart_tx === 1'b0) low1++;
            else if (phase == 0) begin
                phase = 1;
                high1 = 1;
            end else if (phase == 1 && uart_tx === 1'b1) high1++;
            else phase = 2;
            @(negedge clk);
            lim--;
        end
        checks++;
        if (busy_n !== FRAME_CYC) begin
            errors++;
            $display("FAIL timing_busy got %0d cycles want %0d", busy_n, FRAME_CYC);
        end
        checks++;
        if (low1 !== 2 * BAUD) begin
            errors++;
            $display("FAIL timing_low_run got %0d want %0d", low1, 2 * BAUD);
        end
        checks++;
        if (high1 !== BAUD) begin
            errors++;
            $display("FAIL timing_bit_width got %0d want %0d", high1, BAUD);
        end
    endtask

    task automatic test_write_through();
        logic [15:0] d;
        cyc(3 * BAUD);
        d = rnd_sample();
        send_i     = 1'b1;
        tr_valid_i = 1'b1;
        tr_chn_i   = 3'd2;
        tr_data_i  = d;
        mdl[2]     = sat13(int'($signed(d)));
        snap_m     = mdl;
        @(negedge clk);
        send_i     = 1'b0;
        tr_valid_i = 1'b0;
        recv_frame();
        checks++;
        if (rx_bad !== 0) begin
            errors++;
            $display("FAIL wt_framing got %0d want 0", rx_bad);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL wt_byte%0d got %0h want %0h",
                         k, rx[k], exp_byte(k));
            end
        end
    endtask

    task automatic test_rst_midframe();
        cyc(3 * BAUD);
        for (int c = 0; c < NCH; c++) wr(c, rnd_sample());
        send();
        cyc(3 * 10 * BAUD + 5 * BAUD);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_tx got %b want 1", uart_tx);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy got %b want 0", busy_o);
        end
        rst = 1'b0;
        clear_model();
        cyc(2);
        wr(5, rnd_sample());
        wr(7, rnd_sample());
        send();
        recv_frame();
        checks++;
        if (rx_bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_framing got %0d want 0", rx_bad);
        end
        for (int k = 0; k < FLEN; k++) begin
            checks++;
            if (rx[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL rst_mid_byte%0d got %0h want %0h",
                         k, rx[k], exp_byte(k));
            end
        end
    endtask

    initial begin
        clear_model();
        snap_m = mdl;
        test_reset();
        test_pattern();
        test_saturation();
        test_random();
        test_busy();
        test_timing();
        test_write_through();
        test_rst_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
